// File: rtl/chan_mux_pkg.sv
// Shared types and helpers for the channel mux/arbiter.
// Mode encoding and index-width function.
package chan_mux_pkg;

   typedef enum logic {
      MODE_RR    = 1'b0,
      MODE_FIXED = 1'b1
   } mode_e;

   // Index width for n items, never below one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches from last+1 upward with wrap; one-hot grant.
module rr_arbiter
   import chan_mux_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic [IW:0]   wrap;
   logic [IW-1:0] cidx;
   logic          found;

   // First requester after last, wrapping modulo N.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      wrap    = '0;
      cidx    = '0;
      for (int k = 1; k <= N; k++) begin
         wrap = {1'b0, last} + (IW+1)'(k);
         if (wrap >= (IW+1)'(N))
            cidx = IW'(wrap - (IW+1)'(N));
         else
            cidx = wrap[IW-1:0];
         if (!found && req[cidx]) begin
            found     = 1'b1;
            gnt[cidx] = 1'b1;
            gnt_idx   = cidx;
         end
      end
   end

endmodule

// File: rtl/chan_mux_arb.sv
// Registered N-channel bus selector with arbitration.
// One-entry output register, tri-state bus, transfer counter.
module chan_mux_arb
   import chan_mux_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   parameter  int CNT_W    = 16,
   localparam int SW       = idx_w(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [SW-1:0]             sel,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic [CHANNELS-1:0]       in_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   input  logic                      out_ready,
   input  logic                      oe,
   output logic [WIDTH-1:0]          bus_out,
   output logic [CNT_W-1:0]          xfer_cnt
);

   mode_e               md;
   logic                load_en;
   logic                xfer;
   logic [SW-1:0]       last_grant;
   logic [CHANNELS-1:0] rr_gnt;
   logic [SW-1:0]       rr_idx;
   logic [CHANNELS-1:0] fix_gnt;
   logic [CHANNELS-1:0] gnt;
   logic [WIDTH-1:0]    mux_data;

   assign md = mode_e'(mode);

   rr_arbiter #(
      .N (CHANNELS)
   ) u_rr (
      .req     (in_valid),
      .last    (last_grant),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx)
   );

   // Fixed select; an out-of-range sel matches no channel.
   always_comb begin
      fix_gnt = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (int'(sel) == i)
            fix_gnt[i] = in_valid[i];
      end
   end

   assign gnt = (md == MODE_FIXED) ? fix_gnt : rr_gnt;

   assign load_en = ~out_valid | out_ready;

   assign in_ready = rst_n ?
                     (gnt & {CHANNELS{load_en}}) :
                     '0;

   assign xfer = |(in_valid & in_ready);

   // Data of the granted channel; zero when nothing is granted.
   always_comb begin
      mux_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (gnt[i])
            mux_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   // Output register: load on transfer, clear valid on bare drain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= mux_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Round-robin pointer; frozen while in fixed mode.
   always_ff @(posedge clk) begin
      if (!rst_n)
         last_grant <= SW'(CHANNELS - 1);
      else if (xfer && md == MODE_RR)
         last_grant <= rr_idx;
   end

   // Accepted-transfer counter, wraps naturally.
   always_ff @(posedge clk) begin
      if (!rst_n)
         xfer_cnt <= '0;
      else if (xfer)
         xfer_cnt <= xfer_cnt + 1'b1;
   end

   assign bus_out = oe ? out_data : 'z;

endmodule

// File: tb/tb_chan_mux_arb.sv
// Bench for chan_mux_arb: vector table plus scoreboard.
// A second instance with a 4-bit counter covers wrap.
module tb_chan_mux_arb;
   import chan_mux_pkg::*;

   localparam logic [31:0] D0 = 32'hA3A2A1A0;
   localparam logic [31:0] D1 = 32'hA35CA1A0;

   typedef struct {
      logic        rst_n;
      logic        mode;
      logic [1:0]  sel;
      logic [3:0]  iv;
      logic        ordy;
      logic        oe;
      logic [31:0] data;
      logic [3:0]  rdy;
      logic        ov;
      logic [7:0]  od;
      logic [15:0] cnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mode;
   logic [1:0]  sel;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic        out_ready;
   logic        oe;
   logic [3:0]  in_ready, in_ready4;
   logic        out_valid, out_valid4;
   logic [7:0]  out_data, out_data4;
   logic [15:0] cnt;
   logic [3:0]  cnt4;
   wire  [7:0]  bus, bus4;

   int   checks = 0;
   int   errors = 0;
   int   vidx   = 0;
   logic prev_ov = 1'b0;
   logic [7:0] sbq[$];
   vec_t tbl[23];

   always #5 clk = ~clk;

   pullup (bus);
   pullup (bus4);

   chan_mux_arb #(.WIDTH(8), .CHANNELS(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid),
      .out_data(out_data), .out_ready(out_ready),
      .oe(oe), .bus_out(bus), .xfer_cnt(cnt)
   );

   chan_mux_arb #(.WIDTH(8), .CHANNELS(4), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready4), .out_valid(out_valid4),
      .out_data(out_data4), .out_ready(out_ready),
      .oe(oe), .bus_out(bus4), .xfer_cnt(cnt4)
   );

   function automatic vec_t mk(
      input logic r, input logic m, input logic [1:0] s,
      input logic [3:0] iv, input logic ordy, input logic e,
      input logic [31:0] d, input logic [3:0] rdy,
      input logic ov, input logic [7:0] od,
      input logic [15:0] c);
      vec_t v;
      v.rst_n = r; v.mode = m; v.sel = s; v.iv = iv;
      v.ordy = ordy; v.oe = e; v.data = d; v.rdy = rdy;
      v.ov = ov; v.od = od; v.cnt = c;
      return v;
   endfunction

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec=%0d act=%h exp=%h",
                  nm, vidx, act, exp);
      end
   endtask

   task automatic step(input vec_t v);
      logic [7:0] got;
      @(negedge clk);
      rst_n = v.rst_n; mode = v.mode; sel = v.sel;
      in_valid = v.iv; in_data = v.data;
      out_ready = v.ordy; oe = v.oe;
      #1;
      chk("in_ready", {28'd0, in_ready}, {28'd0, v.rdy});
      chk("in_ready4", {28'd0, in_ready4}, {28'd0, v.rdy});
      if (v.rst_n && prev_ov && v.ordy) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_empty vec=%0d act=%h exp=word",
                     vidx, out_data);
         end else begin
            got = sbq.pop_front();
            checks--;
            chk("sb_data", {24'd0, out_data}, {24'd0, got});
         end
      end
      for (int i = 0; i < 4; i++)
         if (v.rdy[i]) sbq.push_back(v.data[i*8 +: 8]);
      @(posedge clk);
      #1;
      chk("out_valid", {31'd0, out_valid}, {31'd0, v.ov});
      chk("out_data", {24'd0, out_data}, {24'd0, v.od});
      chk("xfer_cnt", {16'd0, cnt}, {16'd0, v.cnt});
      chk("out_valid4", {31'd0, out_valid4}, {31'd0, v.ov});
      chk("xfer_cnt4", {28'd0, cnt4}, {28'd0, v.cnt[3:0]});
      chk("bus_out", {24'd0, bus},
          {24'd0, (v.oe ? v.od : 8'hFF)});
      chk("bus_out4", {24'd0, bus4},
          {24'd0, (v.oe ? v.od : 8'hFF)});
      if (!v.rst_n) sbq.delete();
      prev_ov = v.ov;
      vidx++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog vec=%0d act=timeout exp=finish", vidx);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; mode = 1'b0; sel = 2'd0;
      in_valid = 4'h0; in_data = D0;
      out_ready = 1'b1; oe = 1'b1;

      //           r  m  sel  iv    ordy oe data rdy   ov od     cnt
      tbl[0]  = mk(0, 0, 2'd0, 4'hF, 1, 1, D0, 4'h0, 0, 8'h00, 0);
      tbl[1]  = mk(0, 0, 2'd0, 4'hF, 1, 1, D0, 4'h0, 0, 8'h00, 0);
      tbl[2]  = mk(1, 0, 2'd0, 4'hF, 1, 1, D0, 4'h1, 1, 8'hA0, 1);
      tbl[3]  = mk(1, 0, 2'd0, 4'hF, 1, 1, D0, 4'h2, 1, 8'hA1, 2);
      tbl[4]  = mk(1, 0, 2'd0, 4'hF, 1, 1, D0, 4'h4, 1, 8'hA2, 3);
      tbl[5]  = mk(1, 0, 2'd0, 4'hF, 1, 1, D0, 4'h8, 1, 8'hA3, 4);
      tbl[6]  = mk(1, 0, 2'd0, 4'hF, 1, 1, D0, 4'h1, 1, 8'hA0, 5);
      tbl[7]  = mk(1, 1, 2'd2, 4'hF, 1, 1, D0, 4'h4, 1, 8'hA2, 6);
      tbl[8]  = mk(1, 1, 2'd3, 4'h7, 1, 1, D0, 4'h0, 0, 8'hA2, 6);
      tbl[9]  = mk(1, 1, 2'd3, 4'h7, 1, 1, D0, 4'h0, 0, 8'hA2, 6);
      tbl[10] = mk(1, 0, 2'd0, 4'h4, 1, 1, D1, 4'h4, 1, 8'h5C, 7);
      tbl[11] = mk(1, 0, 2'd0, 4'hF, 0, 1, D1, 4'h0, 1, 8'h5C, 7);
      tbl[12] = mk(1, 0, 2'd0, 4'hF, 0, 1, D1, 4'h0, 1, 8'h5C, 7);
      tbl[13] = mk(1, 0, 2'd0, 4'hF, 0, 1, D1, 4'h0, 1, 8'h5C, 7);
      tbl[14] = mk(1, 0, 2'd0, 4'hF, 1, 1, D1, 4'h8, 1, 8'hA3, 8);
      tbl[15] = mk(1, 0, 2'd0, 4'h0, 0, 0, D0, 4'h0, 1, 8'hA3, 8);
      tbl[16] = mk(1, 0, 2'd0, 4'h0, 0, 1, D0, 4'h0, 1, 8'hA3, 8);
      tbl[17] = mk(1, 0, 2'd0, 4'h0, 1, 0, D0, 4'h0, 0, 8'hA3, 8);
      tbl[18] = mk(1, 0, 2'd0, 4'h1, 1, 1, D0, 4'h1, 1, 8'hA0, 9);
      tbl[19] = mk(1, 0, 2'd0, 4'hF, 0, 1, D0, 4'h0, 1, 8'hA0, 9);
      tbl[20] = mk(0, 0, 2'd0, 4'hF, 0, 1, D0, 4'h0, 0, 8'h00, 0);
      tbl[21] = mk(1, 0, 2'd0, 4'hF, 1, 1, D0, 4'h1, 1, 8'hA0, 1);
      tbl[22] = mk(1, 0, 2'd0, 4'h0, 1, 1, D0, 4'h0, 0, 8'hA0, 1);

      for (int i = 0; i < 23; i++)
         step(tbl[i]);

      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL sb_left act=%0d exp=0", sbq.size());
      end

      step(mk(0, 0, 2'd0, 4'hF, 1, 1, D0, 4'h0, 0, 8'h00, 0));
      for (int k = 0; k < 17; k++)
         step(mk(1, 0, 2'd0, 4'hF, 1, 1, D0,
                 4'(4'h1 << (k % 4)), 1,
                 8'(8'hA0 + (k % 4)), 16'(k + 1)));
      chk("wrap_cnt4", {28'd0, cnt4}, 32'd1);
      chk("wrap_cnt16", {16'd0, cnt}, 32'd17);
      step(mk(1, 0, 2'd0, 4'h0, 1, 1, D0, 4'h0, 0, 8'hA0, 17));

      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL sb_left_wrap act=%0d exp=0", sbq.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
